// File: rtl/puf_ro_eval_if.sv
// Request/result bundle between the PUF challenge/response controller (master)
// and the ring-oscillator pair evaluator (slave).
interface puf_ro_eval_if #(
    parameter int N_RO  = 8,
    parameter int CNT_W = 16,
    parameter int WIN_W = 16,
    parameter int SEL_W = $clog2(N_RO)
);
    logic             i_start;
    logic [SEL_W-1:0] i_sel_a;
    logic [SEL_W-1:0] i_sel_b;
    logic [WIN_W-1:0] i_win;
    logic             o_busy;
    logic             o_valid;
    logic             o_resp;
    logic             o_tie;
    logic             o_err;
    logic [CNT_W-1:0] o_cnt_a;
    logic [CNT_W-1:0] o_cnt_b;

    modport master (
        output i_start, i_sel_a, i_sel_b, i_win,
        input  o_busy, o_valid, o_resp, o_tie, o_err, o_cnt_a, o_cnt_b
    );

    modport slave (
        input  i_start, i_sel_a, i_sel_b, i_win,
        output o_busy, o_valid, o_resp, o_tie, o_err, o_cnt_a, o_cnt_b
    );
endinterface

// File: rtl/puf_ro_eval.sv
// Ring-oscillator PUF evaluator: enables a challenge-selected RO pair, counts
// synchronized rising edges of each over a window and compares the two counts.
module puf_ro_eval #(
    parameter int N_RO       = 8,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    puf_ro_eval_if.slave    io_bus,
    input  logic [N_RO-1:0] i_ro,
    output logic [N_RO-1:0] o_ro_en
);
    localparam int SEL_W = $clog2(N_RO);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_CMP,
        S_ERR
    } state_t;

    state_t           r_state;
    logic [SEL_W-1:0] r_sel_a;
    logic [SEL_W-1:0] r_sel_b;
    logic [WIN_W-1:0] r_win;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;
    logic [N_RO-1:0]  r_sync1;
    logic [N_RO-1:0]  r_sync2;
    logic [N_RO-1:0]  r_prev;
    logic [N_RO-1:0]  r_ro_en;
    logic             r_busy;
    logic             r_valid;
    logic             r_resp;
    logic             r_tie;
    logic             r_err;
    logic [CNT_W-1:0] r_res_a;
    logic [CNT_W-1:0] r_res_b;

    logic [N_RO-1:0]  w_edge;
    logic [N_RO-1:0]  w_en_pair;
    logic             w_illegal;
    logic [CNT_W-1:0] w_cnt_a_nxt;
    logic [CNT_W-1:0] w_cnt_b_nxt;

    // Every RO bit is synchronized continuously, so the edge detector is
    // already primed for whichever pair gets selected.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= i_ro;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_comb begin
        w_edge    = r_sync2 & ~r_prev;
        w_illegal = (io_bus.i_sel_a == io_bus.i_sel_b) ||
                    (int'(io_bus.i_sel_a) >= N_RO) ||
                    (int'(io_bus.i_sel_b) >= N_RO) ||
                    (io_bus.i_win == '0);
        w_en_pair = '0;
        w_en_pair[io_bus.i_sel_a] = 1'b1;
        w_en_pair[io_bus.i_sel_b] = 1'b1;
        w_cnt_a_nxt = r_cnt_a;
        w_cnt_b_nxt = r_cnt_b;
        if (r_state == S_COUNT) begin
            if (w_edge[r_sel_a] && (r_cnt_a != CNT_MAX)) w_cnt_a_nxt = r_cnt_a + 1'b1;
            if (w_edge[r_sel_b] && (r_cnt_b != CNT_MAX)) w_cnt_b_nxt = r_cnt_b + 1'b1;
        end
    end

    // Results are taken from the next-count values so the edge seen in the
    // last COUNT cycle is included in the comparison made on the same edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_sel_a <= '0;
            r_sel_b <= '0;
            r_win   <= '0;
            r_timer <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_ro_en <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_resp  <= 1'b0;
            r_tie   <= 1'b0;
            r_err   <= 1'b0;
            r_res_a <= '0;
            r_res_b <= '0;
        end else begin
            r_valid <= 1'b0;
            r_cnt_a <= w_cnt_a_nxt;
            r_cnt_b <= w_cnt_b_nxt;
            case (r_state)
                S_IDLE: begin
                    if (io_bus.i_start) begin
                        r_sel_a <= io_bus.i_sel_a;
                        r_sel_b <= io_bus.i_sel_b;
                        r_win   <= io_bus.i_win;
                        if (w_illegal) begin
                            r_state <= S_ERR;
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_resp  <= 1'b0;
                            r_tie   <= 1'b0;
                            r_res_a <= '0;
                            r_res_b <= '0;
                        end else begin
                            r_state <= S_SETTLE;
                            r_busy  <= 1'b1;
                            r_ro_en <= w_en_pair;
                            r_timer <= TMR_W'(SETTLE_CYC - 1);
                            r_cnt_a <= '0;
                            r_cnt_b <= '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (r_timer == '0) begin
                        r_state <= S_COUNT;
                        r_timer <= TMR_W'(r_win) - 1'b1;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_COUNT: begin
                    if (r_timer == '0) begin
                        r_state <= S_CMP;
                        r_ro_en <= '0;
                        r_valid <= 1'b1;
                        r_resp  <= (w_cnt_a_nxt > w_cnt_b_nxt);
                        r_tie   <= (w_cnt_a_nxt == w_cnt_b_nxt);
                        r_err   <= 1'b0;
                        r_res_a <= w_cnt_a_nxt;
                        r_res_b <= w_cnt_b_nxt;
                    end else begin
                        r_timer <= r_timer - 1'b1;
                    end
                end
                S_CMP: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                S_ERR: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ro_en        = r_ro_en;
    assign io_bus.o_busy  = r_busy;
    assign io_bus.o_valid = r_valid;
    assign io_bus.o_resp  = r_resp;
    assign io_bus.o_tie   = r_tie;
    assign io_bus.o_err   = r_err;
    assign io_bus.o_cnt_a = r_res_a;
    assign io_bus.o_cnt_b = r_res_b;
endmodule

// File: doc/puf_ro_eval.md
# puf_ro_eval

Parametrised ring-oscillator PUF evaluator. It enables a challenge-selected pair from an external bank of `N_RO` ring oscillators (one `puf_ro` instance per bit of `i_ro`). It counts the rising edges of each selected oscillator over a programmable window in the `i_clk` domain. It then compares the two counts to produce one response bit. It sits between the RO bank and the challenge/response controller of the PUF macro.

## Interface
- `N_RO`, 8: number of ring oscillators in the bank; must be ≥ 2.
- `CNT_W`, 16: edge-counter width.
- `WIN_W`, 16: window-length width.
- `SETTLE_CYC`, 4: `i_clk` cycles the oscillators run before counting starts; must be ≥ 1.
- `SEL_W`, `$clog2(N_RO)`: derived; not overridden.
- `i_clk` input 1: system clock.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_start` input 1: measurement request, sampled on a rising edge of `i_clk`.
- `i_sel_a` input `SEL_W`: challenge, index of RO A.
- `i_sel_b` input `SEL_W`: challenge, index of RO B.
- `i_win` input `WIN_W`: counting window length in `i_clk` cycles.
- `i_ro` input `N_RO`: raw oscillator outputs, asynchronous to `i_clk`.
- `o_ro_en` output `N_RO`: per-oscillator enable.
- `o_busy` output 1: a measurement is in progress.
- `o_valid` output 1: one-cycle pulse indicating that a result is ready.
- `o_resp` output 1: response bit; 1 when `cnt_a > cnt_b`.
- `o_tie` output 1: set when `cnt_a == cnt_b`.
- `o_err` output 1: set when the request was illegal.
- `o_cnt_a` output `CNT_W`: final count for RO A.
- `o_cnt_b` output `CNT_W`: final count for RO B.

## Operation
- **FSM states:** IDLE → SETTLE → COUNT → CMP → IDLE, with an ERR branch.
- **IDLE**
  - `o_busy`=0 and `o_ro_en`=0.
  - On `i_start`=1, latch `i_sel_a`, `i_sel_b` and `i_win`.
  - If the request is illegal (`sel_a==sel_b`, either sel ≥ `N_RO`, or `i_win`==0), go to ERR. Otherwise clear both counters and go to SETTLE.
- **ERR** (1 cycle)
  - Pulse `o_valid`.
  - Set `o_err`=1, `o_resp`=0, `o_tie`=0 and both counts to 0.
  - Return to IDLE.
- **SETTLE**
  - `o_ro_en[sel_a]`=`o_ro_en[sel_b]`=1; all other enable bits stay 0.
  - Lasts exactly `SETTLE_CYC` cycles. No counting.
- **COUNT**
  - Enables stay as in SETTLE. Lasts exactly the latched `win` cycles.
  - Each selected `i_ro` passes through a 2-flop synchronizer, then a rising-edge detector (previous-sample register).
  - Each detected-edge pulse present during a COUNT cycle increments its counter.
  - Counters saturate at 2^`CNT_W`−1 and do not wrap.
- **CMP** (1 cycle)
  - Enables drop to 0.
  - Register `o_resp`=(`cnt_a` > `cnt_b`), `o_tie`=(`cnt_a` == `cnt_b`), `o_err`=0, and the counts.
  - Pulse `o_valid`. Return to IDLE.
- **Unselected RO inputs** are ignored; toggling them never changes a count.
- **Result outputs** (`o_resp`, `o_tie`, `o_err`, `o_cnt_a`, `o_cnt_b`) hold their value until the next `o_valid`.
- **`i_start` while busy** (SETTLE/COUNT/CMP) is ignored. Changing `i_sel_*` or `i_win` mid-measurement has no effect.
- **Frequency constraint:** `i_ro` high and low phases must each be ≥ 2 `i_clk` periods for exact counting. Faster oscillators must be pre-divided outside this block.

## Timing
- **Reset values:** all outputs 0 and FSM in IDLE. Synchronizer, edge and counter registers are 0.
- **Reset mid-measurement:** asynchronous. All enables drop to 0 immediately, no `o_valid` is generated, and the previous result is lost.
- **Legal request** with `i_start` sampled at edge T:
  - `o_busy`=1 and enables are high from T+1.
  - COUNT occupies T+1+`SETTLE_CYC` … T+`SETTLE_CYC`+`win`.
  - `o_valid` is high during cycle T+1+`SETTLE_CYC`+`win` (the CMP cycle), with results valid in that same cycle.
  - `o_busy` falls at T+2+`SETTLE_CYC`+`win`.
  - A new `i_start` sampled in the `o_valid` cycle is ignored. The earliest accepted start is the cycle after.
- **Illegal request:** `o_valid`=1 and `o_err`=1 in cycle T+1; `o_busy` stays 0.
- **Synchronizer latency:** 2 cycles. Edges occurring in the last 2 cycles of the window are not counted. This is intended.
- **Edge detector at COUNT entry:** the detector is primed during SETTLE, so an RO that is already high when COUNT begins is not counted as an edge.

## Test plan
- **Ratio:** reset, then `sel_a`=2 with RO2 period 4 clk and `sel_b`=5 with RO5 period 6 clk, `win`=48 → `o_cnt_a`=12±1, `o_cnt_b`=8±1, `o_resp`=1, `o_tie`=0. `o_valid` is a single pulse exactly `SETTLE_CYC`+`win`+1 cycles after the start edge. Only `o_ro_en` bits 2 and 5 are ever high.
- **Swapped challenge:** swap the selects (`sel_a`=5, `sel_b`=2) → `o_resp`=0. Two identical-period ROs driven in phase → `o_tie`=1, `o_resp`=0.
- **Illegal requests:** `sel_a`=`sel_b`=3, then `sel_a`=0 with `sel_b`=`N_RO`, then `win`=0 → each gives `o_valid`+`o_err` one cycle after start, `o_busy` never 1, `o_ro_en`=0.
- **Saturation:** `CNT_W`=4, RO period 4, `win`=200 → `o_cnt_a`=15, no wrap.
- **Busy and isolation:** assert `i_start` during COUNT with new selects and toggle all unselected RO inputs at max rate → no effect on the result or timing. The original selects are reported.
- **Reset mid-operation:** assert `i_rst_n`=0 mid-COUNT → all outputs 0 asynchronously, no `o_valid`. After release, a fresh measurement reproduces the ratio-case result.
